ifu_fq: RTL and testbench
=========================

Name: ifu_fq

Overview:
- Parametrised next-generation instruction fetch unit with a prefetch queue of configurable depth between instruction memory and decode.
- Replaces the single-PC, stall-signal fetch with a valid/ready interface toward the IDU.
- Keeps static prediction and adds a backward-taken rule for branches.
- Manages instruction-memory requests itself, including kill of wrong-path in-flight responses.

Parameters:
- XLEN, 32, PC/address width.
- FQ_DEPTH, 4, queue entries; power of two, minimum 2.
- BOOT_ADDR, 32'h0000_0000, PC after reset.
- IMEM_AW, 16, instruction memory address bits driven.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- flush_flag  in  1  pipeline flush from execute/commit
- flush_addr  in  XLEN  restart address on flush
- imem_req  out  1  read request this cycle
- imem_addr  out  IMEM_AW  read address, equal to fetch_pc[IMEM_AW-1:0]
- imem_rdata  in  32  read data; valid exactly one cycle after imem_req
- if_valid  out  1  queue head valid
- if_ready  in  1  decode accepts head
- if_pc  out  XLEN  head PC
- if_instr  out  32  head instruction
- if_pred_taken  out  1  head was predicted taken
- fq_count  out  $clog2(FQ_DEPTH)+1  occupied entries

Behaviour:
- Reset (rst==0 at posedge):
  - fetch_pc=BOOT_ADDR, queue empty, in-flight flag clear, kill flag clear.
  - Outputs: imem_req=0, if_valid=0, if_pc=0, if_instr=0, if_pred_taken=0, fq_count=0.
- Request issue:
  - imem_req=1 when rst==1, flush_flag==0, and fq_count + inflight < FQ_DEPTH.
  - inflight is 1 if a request was issued last cycle.
  - On issue, fetch_pc <= fetch_pc+4, unless a redirect occurs in the same cycle.
- Response:
  - In the cycle after an issue, imem_rdata is paired with the registered request PC (resp_pc).
  - The response is enqueued at the clock edge unless killed.
- Predecode of each non-killed response, opcode = instr[6:0]:
  - 1100011 (branch): B-imm sign-extended; predicted taken iff the imm sign bit is 1 (backward).
  - 1101111 (jal): J-imm sign-extended; always taken.
  - 1100111 (jalr): not taken (sequential).
  - All other opcodes: not taken.
  - Target = resp_pc + imm, modulo 2^XLEN.
- Redirect (predicted-taken response):
  - fetch_pc <= target.
  - Any request issued in the same cycle is marked killed; its response one cycle later is not enqueued.
  - Cost: one bubble per taken prediction.
  - if_pred_taken of the enqueued entry = 1.
- Queue:
  - Circular FIFO of {pc, instr, pred_taken}.
  - Head output is registered storage; no bypass. First instruction reaches if_valid 2 cycles after the first request.
  - Dequeue on if_valid && if_ready.
  - Simultaneous enqueue and dequeue: count unchanged.
  - Pointers wrap modulo FQ_DEPTH.
  - The issue rule guarantees no enqueue when full; overflow is a design error (assertion in bench).
  - Empty: if_valid=0; if_pc/if_instr hold last values.
- Flush (highest priority):
  - Queue cleared (fq_count=0, if_valid=0 next cycle).
  - Any in-flight response killed.
  - imem_req=0 in the flush cycle.
  - fetch_pc <= {flush_addr[XLEN-1:2],2'b00}; the first request to it is issued the next cycle.
  - A same-cycle redirect or dequeue is ignored.
- Reset during operation: same as initial reset; in-flight data is discarded.
- Back-pressure: if_ready==0 with a full queue stops issue; entries and order are preserved indefinitely.

Test Plan:
- Reset release, imem holds NOPs (32'h00000013) from 0, if_ready=1 → imem_addr 0,4,8 on consecutive cycles; if_valid rises 2 cycles after the first request; if_pc sequence 0,4,8.
- jal x0,+16 at 0x8 → entry 0x8 has pred_taken=1; the response for 0xC is dropped; the next if_pc after 0x8 is 0x18.
- beq imm=-8 at 0x20 → redirect to 0x18. beq imm=+8 at 0x30 → not taken, next if_pc 0x34. jalr at 0x40 → next if_pc 0x44.
- if_ready=0 for 10 cycles with FQ_DEPTH=4 → fq_count saturates at 4, imem_req=0. After release, the 4 entries drain in order with no loss or duplication.
- flush_flag=1, flush_addr=0x103 while the queue holds 3 entries and one request is in flight → next cycle fq_count=0, if_valid=0; the following request has imem_addr=0x100; the stale response is not enqueued.
- Flush coincident with a predicted-taken response, and rst asserted mid-stream → flush_addr wins; after reset, fetch restarts at BOOT_ADDR with an empty queue.

Source files
------------

// File: rtl/ifu_fq_if.sv
// Fetch-unit bus bundle: the instruction-memory request/response pair and the
// valid/ready hand-off of the queue head toward decode.
interface ifu_fq_if #(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 16
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               if_valid;
    logic               if_ready;
    logic [XLEN-1:0]    if_pc;
    logic [31:0]        if_instr;
    logic               if_pred_taken;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        output if_valid, if_pc, if_instr, if_pred_taken,
        input  if_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        input  if_valid, if_pc, if_instr, if_pred_taken,
        output if_ready
    );
endinterface

// File: rtl/ifu_fq.sv
// Instruction fetch unit: issues imem reads, predecodes responses with static
// prediction (jal and backward branches taken) and buffers them in a FIFO.
module ifu_fq #(
    parameter int              XLEN      = 32,
    parameter int              FQ_DEPTH  = 4,
    parameter logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0000,
    parameter int              IMEM_AW   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_flag,
    input  logic [XLEN-1:0]             flush_addr,
    output logic [$clog2(FQ_DEPTH):0]   fq_count,
    ifu_fq_if.master                    bus
);
    localparam int AW = $clog2(FQ_DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FQ_DEPTH);

    logic [XLEN-1:0] fetch_pc_reg, resp_pc_reg;
    logic            inflight_reg, kill_reg;
    logic [AW:0]     count_reg, count_next, remain;
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;

    logic [XLEN-1:0] pc_mem    [FQ_DEPTH];
    logic [31:0]     instr_mem [FQ_DEPTH];
    logic            pred_mem  [FQ_DEPTH];

    logic            head_valid_reg, head_pred_reg;
    logic [XLEN-1:0] head_pc_reg;
    logic [31:0]     head_instr_reg;

    logic [31:0]     rdata;
    logic [XLEN-1:0] imm, target;
    logic            pred_taken, enq, deq, redirect, issue;
    logic [AW+1:0]   occ;
    logic            unused_addr_lsbs;

    assign rdata            = bus.imem_rdata;
    assign unused_addr_lsbs = ^flush_addr[1:0];

    // Static predecode: only jal and backward conditional branches redirect.
    always_comb begin
        imm        = '0;
        pred_taken = 1'b0;
        unique case (rdata[6:0])
            7'b1100011: begin
                imm        = {{(XLEN-12){rdata[31]}}, rdata[7], rdata[30:25], rdata[11:8], 1'b0};
                pred_taken = rdata[31];
            end
            7'b1101111: begin
                imm        = {{(XLEN-20){rdata[31]}}, rdata[19:12], rdata[20], rdata[30:21], 1'b0};
                pred_taken = 1'b1;
            end
            default: begin
                imm        = '0;
                pred_taken = 1'b0;
            end
        endcase
    end

    assign target   = resp_pc_reg + imm;
    assign enq      = inflight_reg && !kill_reg && !flush_flag;
    assign redirect = enq && pred_taken;
    assign deq      = head_valid_reg && bus.if_ready && !flush_flag;

    // The in-flight slot is reserved so a response always has room on arrival.
    assign occ   = {1'b0, count_reg} + (AW+2)'(inflight_reg);
    assign issue = rst && !flush_flag && (occ < DEPTH_W);

    assign bus.imem_req      = issue;
    assign bus.imem_addr     = fetch_pc_reg[IMEM_AW-1:0];
    assign bus.if_valid      = head_valid_reg;
    assign bus.if_pc         = head_pc_reg;
    assign bus.if_instr      = head_instr_reg;
    assign bus.if_pred_taken = head_pred_reg;
    assign fq_count          = count_reg;

    always_comb begin
        count_next = count_reg;
        unique case ({enq, deq})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    assign rd_ptr_next = deq ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    assign remain      = count_reg - (AW+1)'(deq);

    always_ff @(posedge clk) begin
        if (rst && enq) begin
            pc_mem[wr_ptr_reg]    <= resp_pc_reg;
            instr_mem[wr_ptr_reg] <= rdata;
            pred_mem[wr_ptr_reg]  <= pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_reg   <= BOOT_ADDR;
            resp_pc_reg    <= '0;
            inflight_reg   <= 1'b0;
            kill_reg       <= 1'b0;
            count_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            head_valid_reg <= 1'b0;
            head_pc_reg    <= '0;
            head_instr_reg <= '0;
            head_pred_reg  <= 1'b0;
        end else if (flush_flag) begin
            fetch_pc_reg   <= {flush_addr[XLEN-1:2], 2'b00};
            inflight_reg   <= 1'b0;
            kill_reg       <= 1'b0;
            count_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            head_valid_reg <= 1'b0;
        end else begin
            if (redirect)
                fetch_pc_reg <= target;
            else if (issue)
                fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
            if (issue)
                resp_pc_reg <= fetch_pc_reg;
            inflight_reg <= issue;
            kill_reg     <= issue && redirect;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            if (enq)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            // Head register: next oldest stored entry, else the arriving one, else hold.
            head_valid_reg <= (count_next != '0);
            if (remain != '0) begin
                head_pc_reg    <= pc_mem[rd_ptr_next];
                head_instr_reg <= instr_mem[rd_ptr_next];
                head_pred_reg  <= pred_mem[rd_ptr_next];
            end else if (enq) begin
                head_pc_reg    <= resp_pc_reg;
                head_instr_reg <= rdata;
                head_pred_reg  <= pred_taken;
            end
        end
    end
endmodule

// File: tb/tb_ifu_fq.sv
// Directed bench for ifu_fq: a one-cycle-latency imem model, a dequeue log,
// a table of single-instruction predecode vectors and hand-timed corner cases.
module tb_ifu_fq;
    localparam int XLEN     = 32;
    localparam int FQ_DEPTH = 4;
    localparam int IMEM_AW  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_flag = 1'b0;
    logic [31:0] flush_addr = 32'h0;
    logic [2:0]  fq_count;

    ifu_fq_if #(.XLEN(XLEN), .IMEM_AW(IMEM_AW)) bus ();

    ifu_fq #(.XLEN(XLEN), .FQ_DEPTH(FQ_DEPTH), .BOOT_ADDR(32'h0), .IMEM_AW(IMEM_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_flag (flush_flag),
        .flush_addr (flush_addr),
        .fq_count   (fq_count),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    logic [31:0] prog [256];

    always @(posedge clk)
        bus.imem_rdata <= bus.imem_req ? prog[bus.imem_addr[9:2]] : 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } deq_t;
    deq_t log_q[$];

    always @(negedge clk)
        if (rst && !flush_flag && bus.if_valid && bus.if_ready)
            log_q.push_back('{bus.if_pc, bus.if_instr, bus.if_pred_taken});

    int checks = 0;
    int failures = 0;

    always @(negedge clk)
        if (rst && fq_count > 3'(FQ_DEPTH)) begin
            failures++;
            $display("FAIL overflow: fq_count=%0d exceeds depth %0d", fq_count, FQ_DEPTH);
        end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else
            $display("ok   %s: %h", name, act);
    endtask

    function automatic logic [31:0] log_pc(input int i);
        return (log_q.size() > i) ? log_q[i].pc : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] log_instr(input int i);
        return (log_q.size() > i) ? log_q[i].instr : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] log_pred(input int i);
        return (log_q.size() > i) ? {31'b0, log_q[i].pred} : 32'hDEAD_DEAD;
    endfunction

    task automatic do_flush(input logic [31:0] a);
        @(posedge clk); #1;
        flush_flag = 1'b1;
        flush_addr = a;
        @(posedge clk); #1;
        flush_flag = 1'b0;
        log_q.delete();
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] first_pc;
        logic        pred;
        logic [31:0] next_pc;
    } vec_t;
    vec_t vecs[8];

    initial begin
        bit found;

        vecs[0] = '{"jal_fwd16",   32'h08, 32'h0100_006F, 32'h08, 1'b1, 32'h18};
        vecs[1] = '{"beq_back8",   32'h20, 32'hFE00_0CE3, 32'h20, 1'b1, 32'h18};
        vecs[2] = '{"beq_fwd8",    32'h30, 32'h0000_0463, 32'h30, 1'b0, 32'h34};
        vecs[3] = '{"jalr",        32'h40, 32'h0000_8067, 32'h40, 1'b0, 32'h44};
        vecs[4] = '{"nop",         32'h50, NOP,           32'h50, 1'b0, 32'h54};
        vecs[5] = '{"jal_back32",  32'h60, 32'hFE1F_F06F, 32'h60, 1'b1, 32'h40};
        vecs[6] = '{"unaligned",   32'h73, NOP,           32'h70, 1'b0, 32'h74};
        vecs[7] = '{"lui_sign",    32'h80, 32'h8000_00B7, 32'h80, 1'b0, 32'h84};

        for (int i = 0; i < 256; i++) prog[i] = NOP;
        prog[2] = 32'h0100_006F;    // jal x0,+16 at 0x08
        bus.if_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_imem_req", {31'b0, bus.imem_req}, 32'h0);
        check("rst_if_valid", {31'b0, bus.if_valid}, 32'h0);
        check("rst_if_pc", bus.if_pc, 32'h0);
        check("rst_if_instr", bus.if_instr, 32'h0);
        check("rst_if_pred", {31'b0, bus.if_pred_taken}, 32'h0);
        check("rst_fq_count", {29'b0, fq_count}, 32'h0);

        // Boot fetch: sequential requests, head valid two cycles after first request
        @(posedge clk); #1 rst = 1'b1;
        log_q.delete();
        @(negedge clk);
        check("boot_req0", {31'b0, bus.imem_req}, 32'h1);
        check("boot_addr0", {16'b0, bus.imem_addr}, 32'h0);
        check("boot_valid_c0", {31'b0, bus.if_valid}, 32'h0);
        @(negedge clk);
        check("boot_addr1", {16'b0, bus.imem_addr}, 32'h4);
        check("boot_valid_c1", {31'b0, bus.if_valid}, 32'h0);
        @(negedge clk);
        check("boot_addr2", {16'b0, bus.imem_addr}, 32'h8);
        check("boot_valid_c2", {31'b0, bus.if_valid}, 32'h1);
        check("boot_head_pc", bus.if_pc, 32'h0);
        repeat (6) @(negedge clk);
        check("boot_seq0", log_pc(0), 32'h0);
        check("boot_seq1", log_pc(1), 32'h4);
        check("boot_seq2", log_pc(2), 32'h8);
        check("boot_jal_pred", log_pred(2), 32'h1);
        check("boot_after_jal", log_pc(3), 32'h18);

        // Predecode vectors: restart at addr, check the entry and its successor
        foreach (vecs[i]) begin
            prog[vecs[i].addr[9:2]] = vecs[i].instr;
            do_flush(vecs[i].addr);
            repeat (8) @(negedge clk);
            check({vecs[i].name, "_pc"}, log_pc(0), vecs[i].first_pc);
            check({vecs[i].name, "_instr"}, log_instr(0), vecs[i].instr);
            check({vecs[i].name, "_pred"}, log_pred(0), {31'b0, vecs[i].pred});
            check({vecs[i].name, "_next"}, log_pc(1), vecs[i].next_pc);
        end

        // Back-pressure: queue fills, issue stops, then drains in order
        bus.if_ready = 1'b0;
        do_flush(32'h100);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_count_full", {29'b0, fq_count}, 32'h4);
        check("bp_req_stopped", {31'b0, bus.imem_req}, 32'h0);
        check("bp_head_pc", bus.if_pc, 32'h100);
        @(posedge clk); #1 bus.if_ready = 1'b1;
        repeat (8) @(negedge clk);
        for (int k = 0; k < 5; k++)
            check($sformatf("bp_drain%0d", k), log_pc(k), 32'h100 + 32'(4 * k));

        // Flush with 3 queued entries and one in flight
        bus.if_ready = 1'b0;
        do_flush(32'h200);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (fq_count == 3'd3) found = 1'b1;
        end
        check("fl_reach3", {31'b0, found}, 32'h1);
        check("fl_inflight_noreq", {31'b0, bus.imem_req}, 32'h0);
        flush_flag = 1'b1;
        flush_addr = 32'h103;
        #1 check("fl_req_in_flush", {31'b0, bus.imem_req}, 32'h0);
        @(posedge clk); #1 flush_flag = 1'b0;
        @(negedge clk);
        check("fl_count0", {29'b0, fq_count}, 32'h0);
        check("fl_valid0", {31'b0, bus.if_valid}, 32'h0);
        check("fl_req", {31'b0, bus.imem_req}, 32'h1);
        check("fl_addr", {16'b0, bus.imem_addr}, 32'h100);
        log_q.delete();
        bus.if_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("fl_first", log_pc(0), 32'h100);
        check("fl_second", log_pc(1), 32'h104);

        // Flush in the same cycle as a predicted-taken jal response
        do_flush(32'h08);
        @(posedge clk); #1;
        flush_flag = 1'b1;
        flush_addr = 32'h300;
        @(posedge clk); #1;
        flush_flag = 1'b0;
        log_q.delete();
        @(negedge clk);
        check("flr_req", {31'b0, bus.imem_req}, 32'h1);
        check("flr_addr", {16'b0, bus.imem_addr}, 32'h300);
        repeat (5) @(negedge clk);
        check("flr_first", log_pc(0), 32'h300);
        check("flr_pred", log_pred(0), 32'h0);
        check("flr_second", log_pc(1), 32'h304);

        // Reset mid-stream
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mrst_req", {31'b0, bus.imem_req}, 32'h0);
        check("mrst_valid", {31'b0, bus.if_valid}, 32'h0);
        check("mrst_count", {29'b0, fq_count}, 32'h0);
        check("mrst_pc", bus.if_pc, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        log_q.delete();
        @(negedge clk);
        check("mrst_boot_req", {31'b0, bus.imem_req}, 32'h1);
        check("mrst_boot_addr", {16'b0, bus.imem_addr}, 32'h0);
        repeat (6) @(negedge clk);
        check("mrst_first", log_pc(0), 32'h0);
        check("mrst_second", log_pc(1), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
